// File: rtl/demux_1to8_collect_pkg.sv
// Shared types and helpers for the demux_1to8_collect bit collector.
package demux_1to8_collect_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int unsigned DEMUX_WIDTH_DEFAULT = 8;
    localparam int unsigned DEMUX_MAX_WIDTH     = 64;

    // All-ones mask of the given width, right-aligned in a max-width vector.
    function automatic logic [DEMUX_MAX_WIDTH-1:0] all_ones_mask(input int unsigned width);
        logic [DEMUX_MAX_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DEMUX_MAX_WIDTH; i++) begin
            if (i < width) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/demux_1to8_collect_bit_slot.sv
// demux_bit_slot: one data bit plus its "written" flag.
// With DEMUX_DUP_ERR_EN defined, a write to an already-written slot is
// dropped and flagged on dup; otherwise it simply overwrites.
module demux_bit_slot (
    input  logic clk,
    input  logic rst,
    input  logic wr,
    input  logic wr_bit,
    input  logic clr,
`ifdef DEMUX_DUP_ERR_EN
    output logic dup,
`endif
    output logic data,
    output logic mask
);

`ifdef DEMUX_DUP_ERR_EN
    assign dup = wr & mask;
`endif

    // Data/mask register: write sets the flag, clear drops it and keeps data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= 1'b0;
            mask <= 1'b0;
        end else if (wr) begin
`ifdef DEMUX_DUP_ERR_EN
            if (!mask) begin
                data <= wr_bit;
                mask <= 1'b1;
            end
`else
            data <= wr_bit;
            mask <= 1'b1;
`endif
        end else if (clr) begin
            mask <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to8_collect.sv
// demux_1to8_collect: steers addressed bits into a word register and hands
// the completed word downstream over valid/ready.
// Optional macro DEMUX_DUP_ERR_EN: drop duplicate writes and pulse err.
module demux_1to8_collect
    import demux_1to8_collect_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT,
    parameter int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DEMUX_DUP_ERR_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam logic [WIDTH-1:0] FULL_MASK = WIDTH'(all_ones_mask(WIDTH));

    state_t           state, state_next;
    logic             accept;
    logic             clr;
    logic [WIDTH-1:0] wr_vec;
    logic [WIDTH-1:0] data_vec;
    logic [WIDTH-1:0] mask_vec;

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign clr       = out_valid & out_ready;
    assign out_data  = data_vec;

    // Decode the select into a one-hot write enable for the accepted bit.
    always_comb begin
        wr_vec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            wr_vec[i] = accept && (in_sel == SEL_W'(i));
        end
    end

`ifdef DEMUX_DUP_ERR_EN
    logic [WIDTH-1:0] dup_vec;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_slot
        demux_bit_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr_vec[g]),
            .wr_bit (in_bit),
            .clr    (clr),
`ifdef DEMUX_DUP_ERR_EN
            .dup    (dup_vec[g]),
`endif
            .data   (data_vec[g]),
            .mask   (mask_vec[g])
        );
    end

`ifdef DEMUX_DUP_ERR_EN
    // One-cycle pulse following a duplicate accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= |dup_vec;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: word complete (counting this write) -> HOLD; drained -> COLLECT.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && ((mask_vec | wr_vec) == FULL_MASK)) state_next = HOLD;
            HOLD:    if (out_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_demux_1to8_collect.sv
// Directed, table-driven bench for demux_1to8_collect (WIDTH = 8).
module tb_demux_1to8_collect;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_bit;
    logic [2:0] in_sel;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_1to8_collect #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_DUP_ERR_EN
        .err       (err),
`endif
        .out_data  (out_data)
    );

`ifndef DEMUX_DUP_ERR_EN
    assign err = 1'b0;
`endif

    typedef struct {
        logic       vld;
        logic       b;
        logic [2:0] sel;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] data;
        logic       chk_data;
        logic       err;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic b, input logic [2:0] sel,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [7:0] data, input logic chk_data,
                                input logic e, input string name);
        vec_t v;
        v.vld = vld; v.b = b; v.sel = sel; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.data = data; v.chk_data = chk_data;
        v.err = e; v.name = name;
        return v;
    endfunction

    // Queue the WIDTH accepts of a word in the given select order.
    task automatic add_word(input logic [7:0] w, input int unsigned ord[8],
                            input logic ordy, input string nm);
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1'b1, w[ord[k]], 3'(ord[k]), ordy, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, nm));
        end
    endtask

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, required 0x%0h (t=%0t)", name, what, act, exp, $time);
        end
    endtask

    // Drive one vector, check state-derived outputs, then advance one cycle.
    task automatic apply(input vec_t v);
        in_valid  = v.vld;
        in_bit    = v.b;
        in_sel    = v.sel;
        out_ready = v.ordy;
        #1;
        check(v.name, "in_ready", 32'(in_ready), 32'(v.ir));
        check(v.name, "out_valid", 32'(out_valid), 32'(v.ov));
        if (v.chk_data) check(v.name, "out_data", 32'(out_data), 32'(v.data));
`ifdef DEMUX_DUP_ERR_EN
        check(v.name, "err", 32'(err), 32'(v.err));
`endif
        @(posedge clk);
        #1;
    endtask

    int unsigned ord_fwd[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int unsigned ord_rev[8]  = '{7, 6, 5, 4, 3, 2, 1, 0};
    int unsigned ord_perm[8] = '{3, 0, 6, 1, 7, 2, 5, 4};
    logic [7:0]  dup_exp;
    logic        dup_err;

    initial begin
`ifdef DEMUX_DUP_ERR_EN
        dup_exp = 8'h04;
        dup_err = 1'b1;
`else
        dup_exp = 8'h00;
        dup_err = 1'b0;
`endif
        // In-order fill 0xA5: HOLD in the cycle after the 8th accept, then COLLECT.
        add_word(8'hA5, ord_fwd, 1'b1, "fill_a5");
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, "hold_a5"));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "back_a5"));
        // Reverse order 0x3C.
        add_word(8'h3C, ord_rev, 1'b1, "fill_3c");
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, "hold_3c"));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "back_3c"));
        // Permuted order 0xF0.
        add_word(8'hF0, ord_perm, 1'b1, "fill_f0");
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, "hold_f0"));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "back_f0"));
        // Backpressure 0x81: stall 5 cycles with in_valid pulses that must be ignored.
        add_word(8'h81, ord_fwd, 1'b0, "fill_81");
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(k[0] == 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, "stall_81"));
        end
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, "release_81"));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "back_81"));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "idle_81"));
        // Duplicate select 2: 1 then 0, rest zero.
        vecs.push_back(mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "dup_first"));
        vecs.push_back(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "dup_second"));
        for (int s = 0; s < 8; s++) begin
            if (s != 2) begin
                vecs.push_back(mk(1'b1, 1'b0, 3'(s), 1'b1, 1'b1, 1'b0, 8'h00, 1'b0,
                                  (s == 0) ? dup_err : 1'b0, "dup_fill"));
            end
        end
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, dup_exp, 1'b1, 1'b0, "hold_dup"));
        vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "back_dup"));

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sel = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "in_ready", 32'(in_ready), 32'd1);
        check("reset", "out_valid", 32'(out_valid), 32'd0);
        check("reset", "out_data", 32'(out_data), 32'd0);
        check("reset", "err", 32'(err), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset after 4 accepts discards the partial word.
        for (int s = 0; s < 4; s++) begin
            apply(mk(1'b1, 1'b1, 3'(s), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "partial"));
        end
        in_valid = 1'b0;
        #1;
        check("partial", "out_data", 32'(out_data), 32'h0F);
        rst = 1'b1;
        #1;
        check("rst_mid", "in_ready", 32'(in_ready), 32'd1);
        check("rst_mid", "out_valid", 32'(out_valid), 32'd0);
        check("rst_mid", "out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            dup_exp = 8'h5A;
            apply(mk(1'b1, dup_exp[s], 3'(s), 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "fill_5a"));
        end
        apply(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, "hold_5a"));
        apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "back_5a"));

        // Reset while holding drops the word.
        for (int s = 0; s < 8; s++) begin
            apply(mk(1'b1, 1'b1, 3'(s), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "fill_ff"));
        end
        apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, "hold_ff"));
        rst = 1'b1;
        #1;
        check("rst_hold", "out_valid", 32'(out_valid), 32'd0);
        check("rst_hold", "in_ready", 32'(in_ready), 32'd1);
        check("rst_hold", "out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "after_rst"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to8_collect.md
# demux_1to8_collect

Registered 1-to-8 demultiplexer/collector: the write-side counterpart of the 8-to-1 bit-select mux. It accepts (bit, select) pairs over a valid/ready handshake and steers each bit into the addressed position of an internal byte register. When all positions have been written, it presents the assembled word downstream on a second valid/ready handshake. It sits between a bit-serial or addressed-bit producer and any word-wide consumer.

## Interface
Parameters:
- WIDTH, 8, word width; must be a power of two ≥ 2
- SEL_W, $clog2(WIDTH), select width; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer has a bit
- in_ready  output  1  block can accept a bit
- in_bit  input  1  data bit
- in_sel  input  SEL_W  destination bit position
- out_valid  output  1  assembled word available
- out_ready  input  1  consumer accepts word
- out_data  output  WIDTH  assembled word
- err  output  1  duplicate-write pulse (present only with DEMUX_DUP_ERR_EN)

## Operation
- State machine with states COLLECT and HOLD; reset state is COLLECT.
- Internal registers: data[WIDTH-1:0] and written mask[WIDTH-1:0], both cleared on reset.
- COLLECT:
  - in_ready = 1 and out_valid = 0.
  - On accept (in_valid & in_ready): data[in_sel] <= in_bit and mask[in_sel] <= 1.
  - If the mask, including the current write, becomes all-ones, transition to HOLD.
  - Selects may arrive in any order.
- HOLD:
  - in_ready = 0, out_valid = 1, and out_data = data, held stable.
  - On out_ready: clear the mask, keep data (out_data becomes don't-care), and return to COLLECT.
- Duplicate select (mask bit already set) without the macro: the new bit overwrites and the mask is unchanged.
- out_data is driven from the data register, not gated by out_valid.
- Reset values: in_ready = 1 (combinational from state), out_valid = 0, out_data = 0, err = 0.
- Reset asserted mid-collection discards the partial word. Reset asserted in HOLD drops the pending word with no handshake.

## Timing
- Latency: when the final missing bit is accepted at edge N, out_valid is high after edge N, i.e. in cycle N+1.
- Minimum word period is WIDTH + 1 cycles:
  - WIDTH accepts, then one HOLD cycle if out_ready is already high.
  - in_ready returns to 1 the cycle after the out handshake.
- No same-cycle overlap: the bit stream stalls while in HOLD.
- out_ready held low in HOLD: out_valid and out_data stay constant indefinitely.
- in_valid while in HOLD: ignored (no accept because in_ready = 0).
- in_ready depends only on state, never combinationally on out_ready.

## Configuration
- Macro: DEMUX_DUP_ERR_EN.
- Defined:
  - The err port exists.
  - A COLLECT accept whose mask[in_sel] is already 1 is dropped: data and mask are unchanged.
  - err is a registered 1-cycle pulse in the following cycle.
  - The bit still counts as accepted (handshake completes).
- Undefined: no err port, and duplicates overwrite as described in Operation.

## Structure
- The shared package holds:
  - state typedef (COLLECT, HOLD)
  - DEMUX_WIDTH_DEFAULT = 8
  - a function computing the all-ones mask for a given WIDTH
- One natural sub-module: demux_bit_slot, a single-bit data and mask register with write-enable, clear and duplicate-detect. It is instantiated WIDTH times via generate. The FSM and handshakes stay in the top.

## Test plan
- In-order fill: in_sel 0..7 with bits of 0xA5 on consecutive cycles, out_ready = 1 → out_valid high in the cycle after the 8th accept with out_data = 0xA5; in_ready high again one cycle later.
- Reverse and random order: in_sel 7..0 carrying bits of 0x3C, then permutation 3,0,6,1,7,2,5,4 carrying 0xF0 → out_data = 0x3C, then 0xF0, with identical latency.
- Backpressure: complete a word 0x81 with out_ready = 0 for 5 cycles → out_valid = 1, out_data = 0x81 stable, in_ready = 0 throughout, and in_valid pulses in HOLD are ignored; release out_ready → one handshake, then COLLECT.
- Duplicate select: write sel 2 = 1, then sel 2 = 0, then fill the rest with 0 →
  - without macro: out_data = 0x00
  - with DEMUX_DUP_ERR_EN: out_data = 0x04, and err pulses exactly once, one cycle after the second sel-2 accept
- Reset mid-operation: assert rst after 4 accepts, then after reset write all 8 bits of 0x5A → out_data = 0x5A with no leftover bits; a separate run resets in HOLD → out_valid = 0 immediately and in_ready = 1.
